tile_scheduler: RTL and testbench



---
 rtl/tile_pkg.sv | 22 ++
 rtl/lane_lfsr.sv | 34 +++
 rtl/tile_scheduler.sv | 167 ++++++++++++++++
 tb/tb_tile_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the four-lane tile game.
//   game_state_e : encoding of the game_state output (title / play / over)
//   LANES        : number of lanes (width of the one-hot lane mask)
//   *_DEF        : default screen and tile geometry
//   lane_onehot  : converts a 2-bit lane index into a one-hot lane mask
package tile_pkg;

    localparam int LANES        = 4;
    localparam int SCREEN_H_DEF = 480;
    localparam int TILE_H_DEF   = 100;

    typedef enum logic [1:0] {
        GS_TITLE = 2'd0,
        GS_PLAY  = 2'd1,
        GS_OVER  = 2'd2
    } game_state_e;

    function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] sel);
        return LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/lane_lfsr.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, used to pick spawn lanes.
//   clk_d : clock
//   rst   : synchronous active-high reset, loads SEED (must be non-zero)
//   en    : advance one step this cycle
//   lfsr  : current register value
module lane_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_d,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Right-shifting Galois form: the bit falling out of bit 0 is fed back
    // into the tap positions of x^8, x^6, x^5, x^4 (mask 8'hB8).
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/tile_scheduler.sv
// Game sequencer: owns title/play/over state, spawns and moves the single
// active tile, judges lane buttons and keeps score.
//   clk_d, rst            : clock, synchronous active-high reset
//   frame_tick            : one pulse per frame (start of vblank)
//   start_button          : start level (synchronised)
//   button_1..button_4    : lane button levels (synchronised)
//   game_state            : 0 title, 1 play, 2 over
//   state                 : one-hot lane mask of active tile, 0 if none
//   tile_top              : top line of active tile
//   tile_hit              : active tile has been hit (drawn cleared)
//   st_chng               : one-cycle pulse on spawn
//   score                 : hit count, saturating at 1023
module tile_scheduler
    import tile_pkg::*;
#(
    parameter int         SCREEN_H   = SCREEN_H_DEF,
    parameter int         TILE_H     = TILE_H_DEF,
    parameter int         SPEED_INIT = 1,
    parameter int         SPEED_MAX  = 8,
    parameter int         LEVEL_PTS  = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk_d,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_button,
    input  logic       button_1,
    input  logic       button_2,
    input  logic       button_3,
    input  logic       button_4,
    output logic [1:0] game_state,
    output logic [3:0] state,
    output logic [9:0] tile_top,
    output logic       tile_hit,
    output logic       st_chng,
    output logic [9:0] score
);

    // Bit 0 is start, bits 4:1 are lanes 1..4 so lane bits line up with state.
    logic [4:0] btn_now, btn_q, btn_d, rise;
    logic [3:0] lane_rise;

    game_state_e gs_q, gs_d;
    logic [3:0]  state_q, state_d;
    logic [9:0]  top_q, top_d;
    logic        hit_q, hit_d;
    logic        chg_q, chg_d;
    logic [9:0]  score_q, score_d;
    logic [9:0]  speed_q, speed_d;
    logic [9:0]  lvl_q, lvl_d;

    logic [7:0]  lfsr;
    logic        lfsr_unused;
    logic        active, lane_good, lane_bad;
    logic [10:0] move_bottom;

    lane_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_d (clk_d),
        .rst   (rst),
        .en    (1'b1),
        .lfsr  (lfsr)
    );

    // Only the low two bits choose the lane.
    assign lfsr_unused = ^lfsr[7:2];

    assign btn_now   = {button_4, button_3, button_2, button_1, start_button};
    assign btn_d     = btn_now;
    assign rise      = btn_now & ~btn_q;
    assign lane_rise = rise[4:1];

    assign active    = (state_q != 4'd0) && !hit_q;
    // Any non-matching lane rising is fatal, even alongside the matching one.
    assign lane_good = active && (lane_rise != 4'd0) && (lane_rise == state_q);
    assign lane_bad  = active && (lane_rise != 4'd0) && (lane_rise != state_q);
    // Bottom edge after a move, widened so the overflow compare is exact.
    assign move_bottom = {1'b0, top_q} + {1'b0, speed_q} + 11'(TILE_H);

    always_comb begin
        gs_d    = gs_q;
        state_d = state_q;
        top_d   = top_q;
        hit_d   = hit_q;
        chg_d   = 1'b0;
        score_d = score_q;
        speed_d = speed_q;
        lvl_d   = lvl_q;

        unique case (gs_q)
            GS_TITLE: begin
                if (rise[0]) begin
                    gs_d    = GS_PLAY;
                    score_d = 10'd0;
                    speed_d = 10'(SPEED_INIT);
                    lvl_d   = 10'd0;
                    state_d = 4'd0;
                    hit_d   = 1'b0;
                end
            end
            GS_PLAY: begin
                if (lane_bad) begin
                    gs_d = GS_OVER;
                end else begin
                    if (lane_good) begin
                        hit_d = 1'b1;
                        if (score_q != 10'd1023) score_d = score_q + 10'd1;
                        if (lvl_q + 10'd1 == 10'(LEVEL_PTS)) begin
                            lvl_d   = 10'd0;
                            speed_d = (speed_q < 10'(SPEED_MAX)) ? speed_q + 10'd1
                                                                 : 10'(SPEED_MAX);
                        end else begin
                            lvl_d = lvl_q + 10'd1;
                        end
                    end
                    if (frame_tick) begin
                        if (!active) begin
                            state_d = lane_onehot(lfsr[1:0]);
                            top_d   = 10'd0;
                            hit_d   = 1'b0;
                            chg_d   = 1'b1;
                        end else if (!lane_good) begin
                            // A hit in the same cycle freezes the tile instead.
                            if (move_bottom > 11'(SCREEN_H)) gs_d  = GS_OVER;
                            else                             top_d = top_q + speed_q;
                        end
                    end
                end
            end
            GS_OVER: begin
                if (button_1 && button_2) gs_d = GS_TITLE;
            end
            default: gs_d = GS_TITLE;
        endcase
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            btn_q   <= '0;
            gs_q    <= GS_TITLE;
            state_q <= '0;
            top_q   <= '0;
            hit_q   <= 1'b0;
            chg_q   <= 1'b0;
            score_q <= '0;
            speed_q <= 10'(SPEED_INIT);
            lvl_q   <= '0;
        end else begin
            btn_q   <= btn_d;
            gs_q    <= gs_d;
            state_q <= state_d;
            top_q   <= top_d;
            hit_q   <= hit_d;
            chg_q   <= chg_d;
            score_q <= score_d;
            speed_q <= speed_d;
            lvl_q   <= lvl_d;
        end
    end

    assign game_state = gs_q;
    assign state      = state_q;
    assign tile_top   = top_q;
    assign tile_hit   = hit_q;
    assign st_chng    = chg_q;
    assign score      = score_q;

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

    localparam int         SCREEN_H   = 480;
    localparam int         TILE_H     = 100;
    localparam int         SPEED_INIT = 1;
    localparam int         SPEED_MAX  = 8;
    localparam int         LEVEL_PTS  = 8;
    localparam logic [7:0] SEED       = 8'hA5;

    logic       clk_d = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_button = 1'b0;
    logic       button_1 = 1'b0, button_2 = 1'b0, button_3 = 1'b0, button_4 = 1'b0;
    logic [1:0] game_state;
    logic [3:0] state;
    logic [9:0] tile_top;
    logic       tile_hit;
    logic       st_chng;
    logic [9:0] score;

    tile_scheduler #(
        .SCREEN_H(SCREEN_H), .TILE_H(TILE_H), .SPEED_INIT(SPEED_INIT),
        .SPEED_MAX(SPEED_MAX), .LEVEL_PTS(LEVEL_PTS), .LFSR_SEED(SEED)
    ) dut (
        .clk_d(clk_d), .rst(rst), .frame_tick(frame_tick), .start_button(start_button),
        .button_1(button_1), .button_2(button_2), .button_3(button_3), .button_4(button_4),
        .game_state(game_state), .state(state), .tile_top(tile_top), .tile_hit(tile_hit),
        .st_chng(st_chng), .score(score)
    );

    always #5 clk_d = ~clk_d;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference LFSR: multiply by x modulo x^8+x^6+x^5+x^4+1 in shift-right Galois form.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    logic [7:0] m_lfsr;
    always @(posedge clk_d) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

    // Game-level model
    int         e_gs, e_top, e_score, e_speed, e_lvl;
    logic [3:0] e_state;
    bit         e_hit, e_chg;
    logic       p_st;
    logic [3:0] p_b;
    logic [7:0] last_lfsr;

    wire [27:0] obs = {game_state, state, tile_top, tile_hit, st_chng, score};

    function automatic logic [27:0] exp_vec();
        return {2'(e_gs), e_state, 10'(e_top), e_hit, e_chg, 10'(e_score)};
    endfunction

    task automatic model_reset();
        e_gs = 0; e_top = 0; e_score = 0; e_speed = SPEED_INIT; e_lvl = 0;
        e_state = 4'd0; e_hit = 0; e_chg = 0; p_st = 1'b0; p_b = 4'd0;
    endtask

    task automatic model_edge(input logic ft, input logic st, input logic [3:0] b,
                              input logic [7:0] lf);
        logic       rs;
        logic [3:0] rl;
        bit         act, good, bad;
        rs = st & ~p_st;
        rl = b & ~p_b;
        p_st = st;
        p_b  = b;
        e_chg = 0;
        act  = (e_state != 4'd0) && !e_hit;
        good = act && (rl != 4'd0) && (rl == e_state);
        bad  = act && (rl != 4'd0) && (rl != e_state);
        if (e_gs == 0) begin
            if (rs) begin
                e_gs = 1; e_score = 0; e_speed = SPEED_INIT; e_lvl = 0;
                e_state = 4'd0; e_hit = 0;
            end
        end else if (e_gs == 1) begin
            if (bad) e_gs = 2;
            else begin
                if (good) begin
                    e_hit = 1;
                    if (e_score < 1023) e_score++;
                    e_lvl++;
                    if (e_lvl == LEVEL_PTS) begin
                        e_lvl = 0;
                        if (e_speed < SPEED_MAX) e_speed++;
                    end
                end
                if (ft) begin
                    if (!act) begin
                        e_state = 4'(1 << lf[1:0]); e_top = 0; e_hit = 0; e_chg = 1;
                    end else if (!good) begin
                        if (e_top + e_speed + TILE_H > SCREEN_H) e_gs = 2;
                        else e_top += e_speed;
                    end
                end
            end
        end else if (b[0] && b[1]) begin
            e_gs = 0;
        end
    endtask

    // One clock: drive inputs at negedge, update model for the following edge.
    task automatic step(input logic ft, input logic st, input logic [3:0] b, input logic r);
        @(negedge clk_d);
        frame_tick = ft; start_button = st; rst = r;
        {button_4, button_3, button_2, button_1} = b;
        last_lfsr = m_lfsr;
        @(posedge clk_d);
        #1;
        if (r) model_reset();
        else   model_edge(ft, st, b, last_lfsr);
    endtask

    task automatic do_reset_and_start();
        step(0, 0, 4'd0, 1);
        step(0, 0, 4'd0, 0);
        step(0, 1, 4'd0, 0);
        step(0, 0, 4'd0, 0);
    endtask

    // Spawn (or move) then press the active lane and release.
    task automatic do_hit();
        step(1, 0, 4'd0, 0);
        step(0, 0, e_state, 0);
        step(0, 0, 4'd0, 0);
    endtask

    task automatic test_reset();
        step(0, 0, 4'd0, 1);
        n_tests++;
        if (obs !== 28'd0) begin
            n_fail++; $display("FAIL reset_state obs=%h exp=0", obs);
        end
        do_reset_and_start();
        for (int i = 0; i < 5; i++) do_hit();
        n_tests++;
        if (score !== 10'd5 || game_state !== 2'd1) begin
            n_fail++; $display("FAIL pre_reset_score score=%0d gs=%0d exp 5/1", score, game_state);
        end
        step(1, 1, 4'hF, 1);
        n_tests++;
        if (obs !== 28'd0) begin
            n_fail++; $display("FAIL reset_midplay obs=%h exp=0", obs);
        end
    endtask

    task automatic test_spawn();
        do_reset_and_start();
        n_tests++;
        if (game_state !== 2'd1 || state !== 4'd0) begin
            n_fail++; $display("FAIL start_play gs=%0d state=%b exp 1/0000", game_state, state);
        end
        step(1, 0, 4'd0, 0);
        n_tests++;
        if (st_chng !== 1'b1 || tile_top !== 10'd0 || state !== 4'(1 << last_lfsr[1:0])) begin
            n_fail++;
            $display("FAIL spawn chg=%b top=%0d state=%b exp 1/0/%b", st_chng, tile_top, state,
                     4'(1 << last_lfsr[1:0]));
        end
        step(0, 0, 4'd0, 0);
        n_tests++;
        if (st_chng !== 1'b0) begin
            n_fail++; $display("FAIL spawn_pulse_width chg=%b exp 0", st_chng);
        end
    endtask

    task automatic test_hit();
        step(0, 0, e_state, 0);
        n_tests++;
        if (tile_hit !== 1'b1 || score !== 10'd1) begin
            n_fail++; $display("FAIL hit hit=%b score=%0d exp 1/1", tile_hit, score);
        end
        step(0, 0, 4'd0, 0);
        step(1, 0, 4'd0, 0);
        n_tests++;
        if (st_chng !== 1'b1 || tile_top !== 10'd0 || tile_hit !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL respawn obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_wrong();
        logic [3:0] bad_lane;
        bad_lane = {e_state[2:0], e_state[3]};
        step(0, 0, e_state | bad_lane, 0);
        n_tests++;
        if (game_state !== 2'd2 || score !== 10'd1) begin
            n_fail++; $display("FAIL wrong_lane gs=%0d score=%0d exp 2/1", game_state, score);
        end
        step(0, 0, 4'b0011, 0);
        n_tests++;
        if (game_state !== 2'd0) begin
            n_fail++; $display("FAIL over_to_title gs=%0d exp 0", game_state);
        end
        step(0, 0, 4'd0, 0);
    endtask

    task automatic test_miss();
        do_reset_and_start();
        step(1, 0, 4'd0, 0);
        step(0, 0, 4'd0, 0);
        for (int i = 0; i < 380; i++) begin
            step(1, 0, 4'd0, 0);
            step(0, 0, 4'd0, 0);
        end
        n_tests++;
        if (tile_top !== 10'd380 || game_state !== 2'd1) begin
            n_fail++; $display("FAIL miss_last_move top=%0d gs=%0d exp 380/1", tile_top, game_state);
        end
        step(1, 0, 4'd0, 0);
        n_tests++;
        if (game_state !== 2'd2 || tile_top !== 10'd380) begin
            n_fail++; $display("FAIL miss_over gs=%0d top=%0d exp 2/380", game_state, tile_top);
        end
    endtask

    task automatic test_speed();
        do_reset_and_start();
        for (int i = 0; i < 8; i++) do_hit();
        step(1, 0, 4'd0, 0);
        step(0, 0, 4'd0, 0);
        step(1, 0, 4'd0, 0);
        n_tests++;
        if (tile_top !== 10'd2 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL speed_step top=%0d exp 2", tile_top);
        end
        for (int i = 8; i < 100; i++) do_hit();
        step(1, 0, 4'd0, 0);
        step(0, 0, 4'd0, 0);
        step(1, 0, 4'd0, 0);
        n_tests++;
        if (tile_top !== 10'(SPEED_MAX)) begin
            n_fail++; $display("FAIL speed_max top=%0d exp %0d", tile_top, SPEED_MAX);
        end
        for (int i = 100; i < 1030; i++) do_hit();
        n_tests++;
        if (score !== 10'd1023 || game_state !== 2'd1) begin
            n_fail++; $display("FAIL score_sat score=%0d gs=%0d exp 1023/1", score, game_state);
        end
    endtask

    task automatic test_random();
        logic       ft, st;
        logic [3:0] b;
        int         r;
        do_reset_and_start();
        for (int i = 0; i < 4000; i++) begin
            ft = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 7) == 0);
            r  = $urandom_range(0, 9);
            if (r < 6)      b = 4'd0;
            else if (r < 8) b = e_state;
            else            b = 4'($urandom_range(0, 15));
            step(ft, st, b, 0);
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_spawn();
        test_hit();
        test_wrong();
        test_miss();
        test_speed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
